// File: rtl/branch_predict_unit_if.sv
// Fetch/decode-facing signal bundle of branch_predict_unit.
// The master modport is the pipeline side and the slave modport is the predictor.
interface branch_predict_unit_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned STAT_BITS = 16
);
    logic                 lookup_valid;
    logic [XLEN-1:0]      lookup_PC;
    logic                 predict_taken;
    logic                 predict_hit;
    logic [XLEN-1:0]      predict_target;
    logic                 update_valid;
    logic [XLEN-1:0]      update_PC;
    logic                 update_taken;
    logic [XLEN-1:0]      update_target;
    logic                 update_mispredict;
    logic                 clear_tables;
    logic [STAT_BITS-1:0] branch_count;
    logic [STAT_BITS-1:0] mispredict_count;

    modport master (
        output lookup_valid, lookup_PC,
        output update_valid, update_PC, update_taken, update_target, update_mispredict,
        output clear_tables,
        input  predict_taken, predict_hit, predict_target,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  lookup_valid, lookup_PC,
        input  update_valid, update_PC, update_taken, update_target, update_mispredict,
        input  clear_tables,
        output predict_taken, predict_hit, predict_target,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: PC-indexed saturating direction counters plus accuracy stats.
// Defining BRANCH_PREDICT_BTB_EN adds a tagged branch target buffer.
module branch_predict_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned TAG_BITS   = 8,
    parameter int unsigned STAT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    branch_predict_unit_if.slave bus
);
    localparam int unsigned         DEPTH    = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [INDEX_BITS-1:0] lk_idx;
    logic [INDEX_BITS-1:0] up_idx;
    assign lk_idx = bus.lookup_PC[INDEX_BITS+1:2];
    assign up_idx = bus.update_PC[INDEX_BITS+1:2];

    logic [CTR_BITS-1:0]  ctr_q [DEPTH];
    logic [CTR_BITS-1:0]  ctr_upd_d;
    logic [STAT_BITS-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_BITS-1:0] mispredict_cnt_q, mispredict_cnt_d;

    always_comb begin
        ctr_upd_d = ctr_q[up_idx];
        if (bus.update_taken) begin
            if (ctr_upd_d != CTR_MAX) ctr_upd_d = ctr_upd_d + 1'b1;
        end else if (ctr_upd_d != '0) begin
            ctr_upd_d = ctr_upd_d - 1'b1;
        end
    end

    // A flush wins over a concurrent update, which is simply dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
        end else if (bus.clear_tables) begin
            for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
        end else if (bus.update_valid) begin
            ctr_q[up_idx] <= ctr_upd_d;
        end
    end

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (bus.update_valid) begin
            if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + 1'b1;
            if (bus.update_mispredict && (mispredict_cnt_q != '1))
                mispredict_cnt_d = mispredict_cnt_q + 1'b1;
        end
    end

    // Stats keep counting through a table flush; only reset clears them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispredict_cnt_q;

`ifdef BRANCH_PREDICT_BTB_EN
    logic [DEPTH-1:0]    btb_valid_q;
    logic [TAG_BITS-1:0] btb_tag_q [DEPTH];
    logic [XLEN-1:0]     btb_tgt_q [DEPTH];
    logic [TAG_BITS-1:0] lk_tag;
    logic [TAG_BITS-1:0] up_tag;
    logic                btb_wr;
    logic                lk_hit;

    assign lk_tag = bus.lookup_PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign up_tag = bus.update_PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign btb_wr = bus.update_valid & bus.update_taken & ~bus.clear_tables;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btb_valid_q <= '0;
        end else if (bus.clear_tables) begin
            btb_valid_q <= '0;
        end else if (btb_wr) begin
            btb_valid_q[up_idx] <= 1'b1;
        end
    end

    // Tag/target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag_q[up_idx] <= up_tag;
            btb_tgt_q[up_idx] <= bus.update_target;
        end
    end

    assign lk_hit             = bus.lookup_valid & btb_valid_q[lk_idx] & (btb_tag_q[lk_idx] == lk_tag);
    assign bus.predict_hit    = lk_hit;
    assign bus.predict_target = lk_hit ? btb_tgt_q[lk_idx] : '0;
    assign bus.predict_taken  = bus.lookup_valid & ctr_q[lk_idx][CTR_BITS-1] & lk_hit;

    logic unused_bits;
    assign unused_bits = ^{bus.lookup_PC, bus.update_PC};
`else
    assign bus.predict_hit    = 1'b0;
    assign bus.predict_target = '0;
    assign bus.predict_taken  = bus.lookup_valid & ctr_q[lk_idx][CTR_BITS-1];

    logic unused_bits;
    assign unused_bits = ^{bus.lookup_PC, bus.update_PC, bus.update_target};
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed, table-driven bench for branch_predict_unit; expectations adapt to
// whether BRANCH_PREDICT_BTB_EN is defined.
module tb_branch_predict_unit;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned STAT_BITS = 16;
`ifdef BRANCH_PREDICT_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic clk;
    logic rstn;

    branch_predict_unit_if #(.XLEN(XLEN), .STAT_BITS(STAT_BITS)) bif ();

    branch_predict_unit #(
        .XLEN      (XLEN),
        .INDEX_BITS(6),
        .CTR_BITS  (2),
        .TAG_BITS  (8),
        .STAT_BITS (STAT_BITS)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        um;
        logic        clr;
        logic        lv;
        logic [31:0] lpc;
        logic        et;
        logic        eh;
        logic [31:0] etg;
        logic [31:0] ebc;
        logic [31:0] emc;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utgt, input logic um, input logic clr,
                                input logic lv, input logic [31:0] lpc, input logic et,
                                input logic eh, input logic [31:0] etg,
                                input logic [31:0] ebc, input logic [31:0] emc);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.um = um; v.clr = clr;
        v.lv = lv; v.lpc = lpc; v.et = et;
        v.eh = BTB ? eh : 1'b0;
        v.etg = BTB ? etg : 32'h0;
        v.ebc = ebc; v.emc = emc;
        return v;
    endfunction

    task automatic drive(input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic um, input logic clr,
                         input logic lv, input logic [31:0] lpc);
        bif.update_valid = uv; bif.update_PC = upc; bif.update_taken = ut;
        bif.update_target = utgt; bif.update_mispredict = um; bif.clear_tables = clr;
        bif.lookup_valid = lv; bif.lookup_PC = lpc;
    endtask

    task automatic check_lookup(input string nm, input logic et, input logic eh,
                                input logic [31:0] etg);
        chk({nm, " taken"}, 32'(bif.predict_taken), 32'(et));
        chk({nm, " hit"}, 32'(bif.predict_hit), 32'(BTB ? eh : 1'b0));
        chk({nm, " target"}, bif.predict_target, BTB ? etg : 32'h0);
    endtask

    task automatic check_stats(input string nm, input logic [31:0] bc, input logic [31:0] mc);
        chk({nm, " branch_count"}, 32'(bif.branch_count), bc);
        chk({nm, " mispredict_count"}, 32'(bif.mispredict_count), mc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Each row: inputs held for one cycle, outputs checked before that cycle's edge.
        //             uv upc        ut utgt       um clr lv lpc         et              eh etg    bc  mc
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 0, 1, 32'h40,    0,              0, 32'h0,  0, 0));
        vecs.push_back(mk(1, 32'h40,   1, 32'h10,  0, 0, 1, 32'h40,    0,              0, 32'h0,  0, 0));
        vecs.push_back(mk(1, 32'h40,   1, 32'h10,  0, 0, 1, 32'h40,    1,              1, 32'h10, 1, 0));
        vecs.push_back(mk(1, 32'h40,   1, 32'h10,  0, 0, 1, 32'h40,    1,              1, 32'h10, 2, 0));
        vecs.push_back(mk(1, 32'h40,   1, 32'h10,  0, 0, 0, 32'h40,    0,              0, 32'h0,  3, 0));
        vecs.push_back(mk(1, 32'h40,   0, 32'h0,   0, 0, 1, 32'h40,    1,              1, 32'h10, 4, 0));
        vecs.push_back(mk(1, 32'h40,   0, 32'h0,   0, 0, 1, 32'h40,    1,              1, 32'h10, 5, 0));
        vecs.push_back(mk(1, 32'h40,   0, 32'h0,   0, 0, 1, 32'h40,    0,              1, 32'h10, 6, 0));
        vecs.push_back(mk(1, 32'h40,   0, 32'h0,   0, 0, 1, 32'h40,    0,              1, 32'h10, 7, 0));
        vecs.push_back(mk(1, 32'h40,   0, 32'h0,   0, 0, 1, 32'h40,    0,              1, 32'h10, 8, 0));
        vecs.push_back(mk(1, 32'h40,   0, 32'h0,   0, 0, 1, 32'h40,    0,              1, 32'h10, 9, 0));
        vecs.push_back(mk(1, 32'h40,   1, 32'h10,  0, 0, 1, 32'h40,    0,              1, 32'h10, 10, 0));
        vecs.push_back(mk(1, 32'h40,   1, 32'h10,  0, 0, 1, 32'h40,    0,              1, 32'h10, 11, 0));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 0, 1, 32'h40,    1,              1, 32'h10, 12, 0));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 0, 1, 32'h4040,  BTB ? 1'b0 : 1'b1, 0, 32'h0, 12, 0));
        vecs.push_back(mk(1, 32'h80,   1, 32'h200, 0, 1, 1, 32'h40,    1,              1, 32'h10, 12, 0));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 0, 1, 32'h40,    0,              0, 32'h0,  13, 0));
        vecs.push_back(mk(0, 32'h0,    0, 32'h0,   0, 0, 1, 32'h80,    0,              0, 32'h0,  13, 0));

        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].um,
                  vecs[i].clr, vecs[i].lv, vecs[i].lpc);
            #1;
            check_lookup($sformatf("row%0d", i), vecs[i].et, vecs[i].eh, vecs[i].etg);
            check_stats($sformatf("row%0d", i), vecs[i].ebc, vecs[i].emc);
        end

        // Stats: five updates, two flagged as mispredicted.
        do_reset();
        #1;
        check_stats("post_reset", 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1, 32'hC0, 1, 32'h500, (i == 0 || i == 2), 0, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 32'hC0);
        #1;
        check_stats("five_updates", 5, 2);
        check_lookup("c0_trained", 1, 1, 32'h500);

        // Reset lands while an update is being presented; it must be discarded.
        @(negedge clk);
        drive(1, 32'h100, 1, 32'h300, 1, 0, 1, 32'h100);
        #2;
        rstn = 1'b0;
        #1;
        check_stats("mid_reset", 0, 0);
        check_lookup("mid_reset", 0, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h100);
        rstn = 1'b1;
        #1;
        check_lookup("dropped_upd", 0, 0, 32'h0);
        check_stats("after_mid_reset", 0, 0);
        bif.lookup_PC = 32'hC0;
        #1;
        check_lookup("c0_after_reset", 0, 0, 32'h0);

        // Stats saturate at all-ones instead of wrapping.
        @(negedge clk);
        drive(1, 32'h0, 0, 32'h0, 1, 0, 0, 0);
        repeat (65540) @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_stats("saturate", 32'hFFFF, 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
